// File: rtl/encoder_4_to_2_rr.sv
// encoder_4_to_2_rr: registered round-robin/fixed-priority 4-to-2 encoder; in clk,rst,EN,D0-D3,ACK; out A1,A0,V,MULTI,CNT[2:0]
module encoder_4_to_2_rr #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic       D0,
  input  logic       D1,
  input  logic       D2,
  input  logic       D3,
  input  logic       ACK,
  output logic       A1,
  output logic       A0,
  output logic       V,
  output logic       MULTI,
  output logic [2:0] CNT
);
  localparam logic IDLE = 1'b0;
  localparam logic HOLD = 1'b1;
  logic       state;
  logic [1:0] idx, ptr, base, rr_sel, fp_sel, sel;
  logic [3:0] d;
  logic       retire, capture;
  assign d       = {D3, D2, D1, D0};
  assign retire  = state == HOLD && ACK;
  assign capture = EN && |d && (state == IDLE || ACK);
  assign base    = retire ? idx + 2'd1 : ptr;
  always_comb begin
    rr_sel = base;
    for (int k = 3; k >= 0; k--)
      if (d[base + 2'(k)]) rr_sel = base + 2'(k);
  end
  assign fp_sel = d[3] ? 2'd3 : d[2] ? 2'd2 : d[1] ? 2'd1 : 2'd0;
  assign sel    = RR_EN ? rr_sel : fp_sel;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      ptr   <= '0;
      CNT   <= '0;
      MULTI <= 1'b0;
    end else begin
      if (retire) ptr <= idx + 2'd1;
      if (capture) begin
        state <= HOLD;
        idx   <= sel;
        CNT   <= 3'(D0) + 3'(D1) + 3'(D2) + 3'(D3);
        MULTI <= (3'(D0) + 3'(D1) + 3'(D2) + 3'(D3)) > 3'd1;
      end else if (retire) begin
        state <= IDLE;
      end
    end
  end
  assign {A1, A0} = idx;
  assign V        = state == HOLD;
endmodule

// File: tb/tb_encoder_4_to_2_rr.sv
// tb_encoder_4_to_2_rr: random and directed checks of both arbitration modes against a behavioural model
module tb_encoder_4_to_2_rr;
  logic       clk = 1'b0;
  logic       rst, en, ack;
  logic [3:0] d;
  logic       a1 [2], a0 [2], v [2], multi [2];
  logic [2:0] cnt [2];
  int         vectors = 0, miscompares = 0;
  int         m_v [2], m_idx [2], m_cnt [2], m_multi [2], m_ptr [2];

  always #5 clk = ~clk;

  encoder_4_to_2_rr #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst), .EN(en), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]), .ACK(ack),
    .A1(a1[0]), .A0(a0[0]), .V(v[0]), .MULTI(multi[0]), .CNT(cnt[0])
  );
  encoder_4_to_2_rr #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst), .EN(en), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]), .ACK(ack),
    .A1(a1[1]), .A0(a0[1]), .V(v[1]), .MULTI(multi[1]), .CNT(cnt[1])
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_a(input int i);
    return {30'd0, a1[i], a0[i]};
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_v[i] = 0; m_idx[i] = 0; m_cnt[i] = 0; m_multi[i] = 0; m_ptr[i] = 0;
      end else begin
        int  start;
        int  pick;
        bit  retiring;
        retiring = m_v[i] != 0 && ack;
        start = retiring ? (m_idx[i] + 1) % 4 : m_ptr[i];
        if (retiring) m_ptr[i] = (m_idx[i] + 1) % 4;
        if (en && d != 0 && (m_v[i] == 0 || ack)) begin
          pick = -1;
          if (i == 0) begin
            for (int k = 0; k < 4; k++)
              if (pick < 0 && d[(start + k) % 4]) pick = (start + k) % 4;
          end else begin
            for (int k = 3; k >= 0; k--)
              if (pick < 0 && d[k]) pick = k;
          end
          m_idx[i] = pick;
          m_cnt[i] = $countones(d);
          m_multi[i] = m_cnt[i] > 1;
          m_v[i] = 1;
        end else if (retiring) begin
          m_v[i] = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 2; i++) begin
      check(i == 0 ? "rr_v" : "fp_v", int'(v[i]), m_v[i]);
      check(i == 0 ? "rr_a" : "fp_a", dut_a(i), m_idx[i]);
      check(i == 0 ? "rr_cnt" : "fp_cnt", int'(cnt[i]), m_cnt[i]);
      check(i == 0 ? "rr_multi" : "fp_multi", int'(multi[i]), m_multi[i]);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [3:0] dd, input logic k);
    rst = r; en = e; d = dd; ack = k;
  endtask

  int rr_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    foreach (m_v[i]) begin
      m_v[i] = 0; m_idx[i] = 0; m_cnt[i] = 0; m_multi[i] = 0; m_ptr[i] = 0;
    end
    drive(1, 1, 4'b1111, 1);
    repeat (2) begin
      step();
      check("lit_rst_v", int'(v[0]), 0);
      check("lit_rst_a", dut_a(0), 0);
      check("lit_rst_cnt", int'(cnt[0]), 0);
      check("lit_rst_multi", int'(multi[0]), 0);
    end
    drive(0, 1, 4'b0100, 0);
    step();
    check("lit_single_a", dut_a(0), 2);
    check("lit_single_v", int'(v[0]), 1);
    check("lit_single_cnt", int'(cnt[0]), 1);
    check("lit_single_multi", int'(multi[0]), 0);
    drive(0, 1, 4'b0001, 0);
    repeat (3) begin
      step();
      check("lit_hold_a", dut_a(0), 2);
      check("lit_hold_v", int'(v[0]), 1);
    end
    drive(0, 0, 4'b0001, 1);
    step();
    check("lit_ack_v", int'(v[0]), 0);
    drive(1, 0, 4'b0000, 0);
    step();
    drive(0, 1, 4'b1111, 1);
    for (int n = 0; n < 5; n++) begin
      step();
      check("lit_rr_a", dut_a(0), rr_seq[n]);
      check("lit_rr_v", int'(v[0]), 1);
      check("lit_rr_cnt", int'(cnt[0]), 4);
      check("lit_rr_multi", int'(multi[0]), 1);
      check("lit_fp_a", dut_a(1), 3);
    end
    drive(0, 0, 4'b0000, 1);
    step();
    drive(0, 1, 4'b0010, 0);
    step();
    check("lit_skip_first", dut_a(0), 1);
    drive(0, 1, 4'b0011, 1);
    step();
    check("lit_skip_wrap", dut_a(0), 0);
    drive(0, 1, 4'b0110, 1);
    step();
    check("lit_fp_0110", dut_a(1), 2);
    drive(0, 0, 4'b1010, 1);
    step();
    check("lit_en0_v", int'(v[0]), 0);
    drive(0, 0, 4'b1010, 0);
    repeat (2) step();
    drive(0, 0, 4'b1010, 1);
    step();
    check("lit_idle_ack_v", int'(v[0]), 0);
    drive(0, 1, 4'b0010, 0);
    step();
    check("lit_hold01_a", dut_a(0), 1);
    drive(1, 0, 4'b0000, 1);
    step();
    check("lit_midrst_v", int'(v[0]), 0);
    check("lit_midrst_a", dut_a(0), 0);
    drive(0, 1, 4'b1111, 0);
    step();
    check("lit_post_rst_a", dut_a(0), 0);
    check("lit_post_rst_fp", dut_a(1), 3);
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 2) != 0);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/encoder_4_to_2_rr.md
# encoder_4_to_2_rr

Registered 4-to-2 encoder with a valid/acknowledge handshake: the inverse of the 2-to-4 decoder. It takes four request lines D3..D0, selects one according to round-robin or fixed priority, and presents its 2-bit index on A1 A0. The index is held stable with V high until the consumer acknowledges it. The block sits on the request side of any path that later drives a 2-to-4 decoder.

## Interface
Parameters:
- RR_EN, default 1: 1 selects round-robin; 0 selects fixed priority with D3 highest and D0 lowest.

Ports:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: synchronous active-high reset.
- EN, input, 1: capture enable; gates new captures only.
- D0, D1, D2, D3, input, 1 each: request lines, multi-hot allowed.
- ACK, input, 1: consumer accepts the current index; ignored while V=0.
- A1, A0, output, 1 each: registered encoded index.
- V, output, 1: index valid.
- MULTI, output, 1: more than one request was active at capture.
- CNT, output, 3: number of requests active at capture, 0 to 4.

## Operation
- Internal state: IDLE (V=0) or HOLD (V=1). Internal 2-bit pointer `ptr` is used only when RR_EN=1.
- Reset values: A1A0=00, V=0, MULTI=0, CNT=000, ptr=00, state IDLE.
- Rst has priority over every other input.
- Selection, RR_EN=1: scan ptr, ptr+1, ptr+2, ptr+3 (mod 4) and pick the first asserted D.
- Selection, RR_EN=0: pick the highest asserted index.
- Capture: A1A0 ← selected index; CNT ← popcount(D3..D0); MULTI ← (popcount > 1); V ← 1.
- IDLE transitions:
  - EN=1 and any D asserted: capture, go to HOLD.
  - Otherwise stay in IDLE. ACK has no effect.
- HOLD, ACK=0: A1A0, CNT and MULTI are frozen and V stays 1, regardless of D or EN.
- HOLD, ACK=1:
  - ptr ← granted index + 1 (mod 4). This wrap-around means 11 → 00.
  - If EN=1 and any D is asserted, capture again in the same edge and stay in HOLD. The search starts from the updated pointer value, i.e. granted+1, computed combinationally.
  - Otherwise go to IDLE with V=0.
- In IDLE, A1A0, CNT and MULTI keep their last captured values. Consumers qualify them with V.
- D is sampled only on capture edges. No input latching outside a capture.
- Fairness: with all requests held and ACK high every cycle, each index is granted once every 4 cycles.

## Timing
- Latency: request to V=1 is 1 clock. The index is visible after the capture edge.
- Throughput: one grant per cycle when ACK is held high (back-to-back, no bubble).
- ACK and a new capture on the same edge: the old index retires and the new index is valid immediately after that edge.
- A deassertion of EN in HOLD does not drop V. Only ACK or rst clears V.
- D deasserting while in HOLD does not change the held outputs.
- Reset mid-HOLD: on the next edge V=0, all outputs return to reset values and ptr=00. The pending index is discarded and never acknowledged.
- Rst and ACK on the same edge: reset wins.

## Test plan
- Reset: rst=1 for 2 cycles with EN=1, D3..D0=1111, ACK=1 → V=0, A1A0=00, CNT=000, MULTI=0 throughout.
- Single request and hold:
  - EN=1, D3..D0=0100, ACK=0 → one edge later A1A0=10, V=1, CNT=001, MULTI=0.
  - Then change D to 0001 for 3 cycles → outputs unchanged.
  - ACK=1 with EN=0 → V=0 next edge.
- Round-robin: RR_EN=1, D3..D0=1111, EN=1, ACK=1 continuously → A1A0 sequence 00, 01, 10, 11, 00 on consecutive cycles. V stays 1 with no gaps. CNT=100, MULTI=1.
- Pointer skip:
  - RR_EN=1, grant index 01.
  - Then D3..D0=0011 with ACK → next grant is 00: scan 10, 11 empty, wraps to 00.
- Fixed priority: RR_EN=0, D3..D0=1111, ACK=1 each cycle → A1A0=11 every cycle. With D3..D0=0110 → A1A0=10.
- Enable, idle ACK and reset mid-HOLD:
  - EN=0 with D3..D0=1010 → V stays 0. ACK pulses in IDLE cause no change.
  - Then reach HOLD with A1A0=01 and assert rst → next edge V=0, A1A0=00.
  - Next capture with D3..D0=1111 → A1A0=00.
